sobel_abs_sched: RTL and testbench

- Scheduler that time-multiplexes one shared combinational Abs unit (12-bit in/out) between the Gx and Gy gradient terms of the convolution datapath.
- Per pixel it accepts a (Gx, Gy) pair and sequences both through Abs. It forms magnitude = |Gx| + |Gy|, saturated to 12 bits.
- It streams results out with row/column position flags.
- Sits between the 3x3 convolution MAC stage and the frame writer.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/sobel_abs_sched_if.sv | 29 ++
 rtl/pix_counter.sv | 50 +++++
 rtl/sobel_abs_sched.sv | 105 ++++++++++
 tb/tb_sobel_abs_sched.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution back end: datapath width,
// scheduler state encoding and the unsigned saturating adder.
package conv_pkg;

   localparam int DATA_W = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ABS_X = 2'd1,
      ABS_Y = 2'd2,
      OUT   = 2'd3
   } state_t;

   // Unsigned add that clamps to all-ones instead of wrapping.
   function automatic logic [DATA_W-1:0] sat_add_u(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
      logic [DATA_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/sobel_abs_sched_if.sv
// Bundle of the scheduler's streaming handshakes and the shared Abs port.
// slave is the scheduler side, master is the surrounding pipeline.
interface sobel_abs_sched_if;
   import conv_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] gx;
   logic [DATA_W-1:0] gy;
   logic [DATA_W-1:0] abs_in;
   logic [DATA_W-1:0] abs_out;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_mag;
   logic              out_eol;
   logic              out_eof;
   logic              busy;

   modport slave (
      input  in_valid, gx, gy, abs_out, out_ready,
      output in_ready, abs_in, out_valid, out_mag, out_eol, out_eof, busy
   );

   modport master (
      output in_valid, gx, gy, abs_out, out_ready,
      input  in_ready, abs_in, out_valid, out_mag, out_eol, out_eof, busy
   );

endinterface

// File: rtl/pix_counter.sv
// Column/row position counter for a raster stream. Advances on inc_i and
// reports whether the current position is the end of a row or of a frame.
module pix_counter #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   output logic eol_o,
   output logic eof_o
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   assign eol_o = (col_q == COL_LAST);
   assign eof_o = eol_o && (row_q == ROW_LAST);

   // Next position: column wraps into a row step, last row wraps the frame.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (inc_i) begin
         if (eol_o) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // Position registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/sobel_abs_sched.sv
// Sequences each (Gx, Gy) pair through one shared external Abs unit and
// emits the saturated magnitude |Gx|+|Gy| tagged with row/frame end flags.
module sobel_abs_sched
   import conv_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic             clk,
   input  logic             rst_n,
   sobel_abs_sched_if.slave bus
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] gx_q, gx_d;
   logic [DATA_W-1:0] gy_q, gy_d;
   logic [DATA_W-1:0] ax_q, ax_d;
   logic [DATA_W-1:0] mag_q, mag_d;
   logic              eol_q, eol_d;
   logic              eof_q, eof_d;
   logic              cnt_inc;
   logic              cnt_eol;
   logic              cnt_eof;

   pix_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_pix_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (cnt_inc),
      .eol_o (cnt_eol),
      .eof_o (cnt_eof)
   );

   // Gy is the last operand used, so outside ABS_X the Abs input simply
   // keeps showing gy_q, which also reads 0 straight out of reset.
   assign bus.abs_in    = (state_q == ABS_X) ? gx_q : gy_q;
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == OUT);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_mag   = mag_q;
   assign bus.out_eol   = eol_q && (state_q == OUT);
   assign bus.out_eof   = eof_q && (state_q == OUT);

   // Next-state and datapath capture for the four-step pixel sequence.
   always_comb begin
      state_d = state_q;
      gx_d    = gx_q;
      gy_d    = gy_q;
      ax_d    = ax_q;
      mag_d   = mag_q;
      eol_d   = eol_q;
      eof_d   = eof_q;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               gx_d    = bus.gx;
               gy_d    = bus.gy;
               state_d = ABS_X;
            end
         end
         ABS_X: begin
            ax_d    = bus.abs_out;
            state_d = ABS_Y;
         end
         ABS_Y: begin
            mag_d   = sat_add_u(ax_q, bus.abs_out);
            eol_d   = cnt_eol;
            eof_d   = cnt_eof;
            state_d = OUT;
         end
         OUT: begin
            if (bus.out_ready) begin
               cnt_inc = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gx_q    <= '0;
         gy_q    <= '0;
         ax_q    <= '0;
         mag_q   <= '0;
         eol_q   <= 1'b0;
         eof_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gx_q    <= gx_d;
         gy_q    <= gy_d;
         ax_q    <= ax_d;
         mag_q   <= mag_d;
         eol_q   <= eol_d;
         eof_q   <= eof_d;
      end
   end

endmodule

// File: tb/tb_sobel_abs_sched.sv
// Randomised bench for sobel_abs_sched on a 4x2 image, with the Abs unit
// modelled here and results compared against a plain arithmetic reference.
module tb_sobel_abs_sched;

   localparam int IMG_W = 4;
   localparam int IMG_H = 2;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   pix_idx;
   int   exp_q[$];

   sobel_abs_sched_if bus ();

   sobel_abs_sched #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // External Abs unit: two's-complement magnitude, 12'h800 maps to 2048.
   assign bus.abs_out = bus.abs_in[11] ? (~bus.abs_in + 12'd1) : bus.abs_in;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input int obs, input int expv);
      n_tests++;
      if (obs != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int ref_mag(input logic [11:0] a, input logic [11:0] b);
      int x, y;
      x = int'($signed(a));
      y = int'($signed(b));
      if (x < 0) x = -x;
      if (y < 0) y = -y;
      return (x + y > 4095) ? 4095 : x + y;
   endfunction

   function automatic int ref_eol(input int idx);
      return ((idx % IMG_W) == IMG_W - 1) ? 1 : 0;
   endfunction

   function automatic int ref_eof(input int idx);
      return ((idx % (IMG_W * IMG_H)) == IMG_W * IMG_H - 1) ? 1 : 0;
   endfunction

   function automatic logic [11:0] rand12();
      if ($urandom_range(0, 7) == 0) return 12'h800;
      return 12'($urandom);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_in_ready"}, bus.in_ready, 1);
      check_eq({tag, "_out_valid"}, bus.out_valid, 0);
      check_eq({tag, "_busy"}, bus.busy, 0);
      check_eq({tag, "_eol"}, bus.out_eol, 0);
      check_eq({tag, "_eof"}, bus.out_eof, 0);
   endtask

   task automatic apply_reset();
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      pix_idx = 0;
      check_idle("rst");
      check_eq("rst_abs_in", bus.abs_in, 0);
      check_eq("rst_out_mag", bus.out_mag, 0);
   endtask

   // One pixel: handshake, Abs operand order, 3-cycle latency, optional
   // backpressure with junk offered on the input, then the output handshake.
   task automatic run_pixel(input logic [11:0] gx_v, input logic [11:0] gy_v, input int stall);
      int exp_mag, exp_eol, exp_eof, guard;
      exp_mag = ref_mag(gx_v, gy_v);
      exp_eol = ref_eol(pix_idx);
      exp_eof = ref_eof(pix_idx);
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
         step();
         guard++;
      end
      check_eq("pre_in_ready", bus.in_ready, 1);
      bus.gx = gx_v;
      bus.gy = gy_v;
      bus.in_valid = 1'b1;
      bus.out_ready = (stall == 0);
      step();
      bus.gx = 12'($urandom);
      bus.gy = 12'($urandom);
      check_eq("absx_operand", bus.abs_in, gx_v);
      check_eq("absx_valid", bus.out_valid, 0);
      check_eq("absx_in_ready", bus.in_ready, 0);
      check_eq("absx_busy", bus.busy, 1);
      step();
      check_eq("absy_operand", bus.abs_in, gy_v);
      check_eq("absy_valid", bus.out_valid, 0);
      step();
      check_eq("out_valid", bus.out_valid, 1);
      check_eq("out_mag", bus.out_mag, exp_mag);
      check_eq("out_eol", bus.out_eol, exp_eol);
      check_eq("out_eof", bus.out_eof, exp_eof);
      for (int s = 0; s < stall; s++) begin
         bus.out_ready = 1'b0;
         bus.gx = 12'($urandom);
         step();
         check_eq("stall_valid", bus.out_valid, 1);
         check_eq("stall_mag", bus.out_mag, exp_mag);
         check_eq("stall_in_ready", bus.in_ready, 0);
         check_eq("stall_eol", bus.out_eol, exp_eol);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      step();
      check_eq("post_valid", bus.out_valid, 0);
      check_eq("post_in_ready", bus.in_ready, 1);
      check_eq("post_eol", bus.out_eol, 0);
      $display("[TB] pix %0d gx=%0d gy=%0d stall=%0d mag=%0d eol=%0d eof=%0d",
               pix_idx, $signed(gx_v), $signed(gy_v), stall, exp_mag, exp_eol, exp_eof);
      pix_idx++;
   endtask

   initial begin
      int n_acc, n_out, last_acc, got;
      bit acc;
      n_tests = 0;
      n_fail = 0;
      pix_idx = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.gx = '0;
      bus.gy = '0;
      bus.out_ready = 1'b1;
      #3;
      check_idle("por");
      check_eq("por_abs_in", bus.abs_in, 0);
      apply_reset();

      // Single pixel, saturation corners, backpressure.
      run_pixel(12'd100, -12'sd120, 0);
      run_pixel(12'h800, 12'h800, 0);
      run_pixel(12'd2000, -12'sd95, 0);
      run_pixel(12'd5, -12'sd7, 10);

      // Frame boundary from a clean start: flags on outputs 4 and 8, none on 9.
      apply_reset();
      for (int i = 0; i < 9; i++) run_pixel(rand12(), rand12(), 0);

      // Reset asserted asynchronously while in ABS_Y.
      bus.gx = 12'd77;
      bus.gy = 12'd99;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("midrst");
      check_eq("midrst_abs_in", bus.abs_in, 0);
      check_eq("midrst_out_mag", bus.out_mag, 0);
      step();
      rst_n = 1'b1;
      pix_idx = 0;
      run_pixel(12'd1, 12'd1, 0);
      for (int i = 0; i < 3; i++) run_pixel(rand12(), rand12(), 0);

      run_pixel(12'd0, 12'd0, 0);

      // Back-to-back with in_valid held high and out_ready tied high.
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.gx = rand12();
      bus.gy = rand12();
      n_acc = 0;
      n_out = 0;
      last_acc = -1;
      for (int c = 0; c < 40; c++) begin
         acc = bus.in_valid && bus.in_ready;
         if (acc) begin
            exp_q.push_back(ref_mag(bus.gx, bus.gy));
            if (last_acc >= 0) check_eq("b2b_gap", c - last_acc, 4);
            last_acc = c;
            n_acc++;
         end
         if (bus.out_valid && bus.out_ready) begin
            got = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            check_eq("b2b_mag", bus.out_mag, got);
            check_eq("b2b_eol", bus.out_eol, ref_eol(pix_idx));
            check_eq("b2b_eof", bus.out_eof, ref_eof(pix_idx));
            $display("[TB] b2b pix %0d mag=%0d", pix_idx, got);
            pix_idx++;
            n_out++;
         end
         step();
         if (acc) begin
            bus.gx = rand12();
            bus.gy = rand12();
         end
      end
      bus.in_valid = 1'b0;
      check_eq("b2b_accepted", n_acc, 10);
      check_eq("b2b_outputs", n_out, 10);
      check_eq("b2b_pending", exp_q.size(), 0);

      // Random pixels with random backpressure.
      for (int i = 0; i < 20; i++) run_pixel(rand12(), rand12(), int'($urandom_range(0, 3)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
